// File: rtl/pwm_counter.sv
// pwm_counter
//   Timebase counter feeding the PWM output stage. A prescaler divides clk
//   into count ticks. The counter runs up or down and wraps at a programmable
//   period. Each wrap raises a one-cycle overflow (up) or underflow (down)
//   pulse. period and prescale are held in shadow registers so that writes
//   made mid-cycle take effect only at a wrap or a restart.
//
// Ports
//   clk          peripheral clock
//   rst_n        asynchronous active-low reset
//   en           counter enable (level)
//   count_reset  synchronous restart pulse; reloads shadows, clears count
//   upnotdown    1 = count up, 0 = count down
//   period       wrap value (live register)
//   prescale     tick every prescale+1 clk cycles (live register)
//   count_val    registered current count
//   overflow     one-cycle pulse on an up-count wrap
//   underflow    one-cycle pulse on a down-count wrap
module pwm_counter #(
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             count_reset,
  input  logic             upnotdown,
  input  logic [CNT_W-1:0] period,
  input  logic [PRE_W-1:0] prescale,
  output logic [CNT_W-1:0] count_val,
  output logic             overflow,
  output logic             underflow
);

  logic [PRE_W-1:0] pre_cnt;
  logic [CNT_W-1:0] period_sh;
  logic [PRE_W-1:0] prescale_sh;

  logic [CNT_W-1:0] count_nxt;
  logic [PRE_W-1:0] pre_nxt;
  logic [CNT_W-1:0] period_sh_nxt;
  logic [PRE_W-1:0] prescale_sh_nxt;
  logic             overflow_nxt;
  logic             underflow_nxt;
  logic             tick;

  assign tick = (pre_cnt == prescale_sh);

  always_comb begin
    count_nxt       = count_val;
    pre_nxt         = pre_cnt;
    period_sh_nxt   = period_sh;
    prescale_sh_nxt = prescale_sh;
    overflow_nxt    = 1'b0;
    underflow_nxt   = 1'b0;

    if (count_reset) begin
      count_nxt       = '0;
      pre_nxt         = '0;
      period_sh_nxt   = period;
      prescale_sh_nxt = prescale;
    end else if (!en) begin
      // While stopped the shadows follow the live registers, so a restart
      // picks up whatever was written in the meantime.
      pre_nxt         = '0;
      period_sh_nxt   = period;
      prescale_sh_nxt = prescale;
    end else begin
      if (tick) begin
        pre_nxt = '0;
      end else begin
        pre_nxt = pre_cnt + 1'b1;
      end

      if (tick) begin
        if (upnotdown) begin
          // >= rather than == so that a count left above a newly shrunk
          // period wraps on the next tick instead of running to 2^CNT_W.
          if (count_val >= period_sh) begin
            count_nxt       = '0;
            overflow_nxt    = 1'b1;
            period_sh_nxt   = period;
            prescale_sh_nxt = prescale;
          end else begin
            count_nxt = count_val + 1'b1;
          end
        end else begin
          if (count_val == '0) begin
            // The reload value is the old shadow. A new period applies from
            // the following wrap.
            count_nxt       = period_sh;
            underflow_nxt   = 1'b1;
            period_sh_nxt   = period;
            prescale_sh_nxt = prescale;
          end else begin
            count_nxt = count_val - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_val   <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      pre_cnt     <= '0;
      period_sh   <= '0;
      prescale_sh <= '0;
    end else begin
      count_val   <= count_nxt;
      overflow    <= overflow_nxt;
      underflow   <= underflow_nxt;
      pre_cnt     <= pre_nxt;
      period_sh   <= period_sh_nxt;
      prescale_sh <= prescale_sh_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_counter.sv
// Directed bench for pwm_counter. The stimulus pushes hand-computed
// expected outputs into a queue. A monitor pops one entry after each rising
// edge and compares it with the DUT outputs.
module tb_pwm_counter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        count_reset;
  logic        upnotdown;
  logic [15:0] period;
  logic [7:0]  prescale;
  logic [15:0] count_val;
  logic        overflow;
  logic        underflow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] cnt;
    logic        ovf;
    logic        unf;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  pwm_counter #(.CNT_W(16), .PRE_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .count_reset(count_reset),
    .upnotdown(upnotdown),
    .period(period),
    .prescale(prescale),
    .count_val(count_val),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk({mon_e.tag, " count_val"}, {16'd0, count_val}, {16'd0, mon_e.cnt});
      chk({mon_e.tag, " overflow"},  {31'd0, overflow},  {31'd0, mon_e.ovf});
      chk({mon_e.tag, " underflow"}, {31'd0, underflow}, {31'd0, mon_e.unf});
    end
  end

  // Drive one cycle of inputs at the falling edge and queue the outputs
  // expected after the following rising edge.
  task automatic cyc(input logic e, input logic cr, input logic up,
                     input logic [15:0] per, input logic [7:0] pre,
                     input logic [15:0] c, input logic o, input logic u,
                     input string tag);
    exp_t x;
    @(negedge clk);
    en = e; count_reset = cr; upnotdown = up; period = per; prescale = pre;
    x.cnt = c; x.ovf = o; x.unf = u; x.tag = tag;
    sb.push_back(x);
  endtask

  initial begin
    logic [15:0] up4 [10];
    logic [15:0] dn3 [8];
    logic [15:0] t4  [11];
    logic [15:0] c;
    logic        o;

    up4 = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    dn3 = '{3, 2, 1, 0, 3, 2, 1, 0};
    t4  = '{6, 7, 8, 9, 0, 1, 2, 0, 1, 2, 0};

    rst_n = 1'b0; en = 1'b0; count_reset = 1'b0; upnotdown = 1'b1;
    period = 16'd4; prescale = 8'd0;
    #12;
    chk("reset count_val", {16'd0, count_val}, 32'd0);
    chk("reset overflow",  {31'd0, overflow},  32'd0);
    chk("reset underflow", {31'd0, underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: up, period 4, prescale 0
    cyc(0, 0, 1, 16'd4, 8'd0, 16'd0, 0, 0, "t1 idle");
    cyc(0, 0, 1, 16'd4, 8'd0, 16'd0, 0, 0, "t1 idle");
    for (int i = 0; i < 10; i++)
      cyc(1, 0, 1, 16'd4, 8'd0, up4[i], (up4[i] == 16'd0), 0, "t1 up");

    // 2: up, period 3, prescale 2 -> value held 3 cycles, overflow every 12
    cyc(1, 1, 1, 16'd3, 8'd2, 16'd0, 0, 0, "t2 restart");
    for (int k = 1; k <= 24; k++) begin
      c = 16'((k / 3) % 4);
      o = ((k % 3) == 0) && (((k / 3) % 4) == 0);
      cyc(1, 0, 1, 16'd3, 8'd2, c, o, 0, "t2 presc");
    end

    // 3: down, period 3
    cyc(1, 1, 0, 16'd3, 8'd0, 16'd0, 0, 0, "t3 restart");
    for (int i = 0; i < 8; i++)
      cyc(1, 0, 0, 16'd3, 8'd0, dn3[i], 0, (dn3[i] == 16'd3), "t3 down");

    // 4: period shrinks from 9 to 2 mid-count; applies after the next wrap
    cyc(1, 1, 1, 16'd9, 8'd0, 16'd0, 0, 0, "t4 restart");
    for (int i = 1; i <= 5; i++)
      cyc(1, 0, 1, 16'd9, 8'd0, 16'(i), 0, 0, "t4 run9");
    for (int i = 0; i < 11; i++)
      cyc(1, 0, 1, 16'd2, 8'd0, t4[i], (t4[i] == 16'd0), 0, "t4 shadow");

    // 5: count_reset with en low at count 7, then async reset mid-count
    cyc(1, 1, 1, 16'd9, 8'd0, 16'd0, 0, 0, "t5 restart");
    for (int i = 1; i <= 7; i++)
      cyc(1, 0, 1, 16'd9, 8'd0, 16'(i), 0, 0, "t5 run");
    cyc(0, 1, 1, 16'd9, 8'd0, 16'd0, 0, 0, "t5 creset");
    for (int i = 1; i <= 3; i++)
      cyc(1, 0, 1, 16'd9, 8'd0, 16'(i), 0, 0, "t5 rerun");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5 async count_val", {16'd0, count_val}, 32'd0);
    chk("t5 async overflow",  {31'd0, overflow},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 6: period 0, prescale 1: pulse every 2 cycles, up then down
    cyc(1, 1, 1, 16'd0, 8'd1, 16'd0, 0, 0, "t6 restart");
    for (int i = 1; i <= 6; i++)
      cyc(1, 0, 1, 16'd0, 8'd1, 16'd0, (i % 2 == 0), 0, "t6 up");
    for (int i = 1; i <= 4; i++)
      cyc(1, 0, 0, 16'd0, 8'd1, 16'd0, 0, (i % 2 == 0), "t6 down");

    // 7: en toggle restarts the prescale cycle; direction change without pulse
    cyc(1, 1, 1, 16'd5, 8'd2, 16'd0, 0, 0, "t7 restart");
    cyc(1, 0, 1, 16'd5, 8'd2, 16'd0, 0, 0, "t7 a");
    cyc(1, 0, 1, 16'd5, 8'd2, 16'd0, 0, 0, "t7 b");
    cyc(1, 0, 1, 16'd5, 8'd2, 16'd1, 0, 0, "t7 tick");
    cyc(1, 0, 1, 16'd5, 8'd2, 16'd1, 0, 0, "t7 c");
    cyc(0, 0, 1, 16'd5, 8'd2, 16'd1, 0, 0, "t7 hold");
    cyc(1, 0, 1, 16'd5, 8'd2, 16'd1, 0, 0, "t7 d");
    cyc(1, 0, 1, 16'd5, 8'd2, 16'd1, 0, 0, "t7 e");
    cyc(1, 0, 1, 16'd5, 8'd2, 16'd2, 0, 0, "t7 resume");
    cyc(1, 0, 0, 16'd5, 8'd2, 16'd2, 0, 0, "t7 f");
    cyc(1, 0, 0, 16'd5, 8'd2, 16'd2, 0, 0, "t7 g");
    cyc(1, 0, 0, 16'd5, 8'd2, 16'd1, 0, 0, "t7 dirchg");

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_counter.md
Name: pwm_counter

Overview:
- Timebase counter that sits directly upstream of the PWM output stage and drives its count_val input.
- Features: programmable prescaler, up or down counting, wrap at a programmable period, and single-cycle overflow/underflow event pulses.
- period and prescale are shadowed, so register writes mid-cycle never produce a truncated or corrupted PWM period.
- All configuration inputs come from the peripheral register file.

Parameters:
- CNT_W, 16, counter and period width.
- PRE_W, 8, prescale field width.

Ports:
- clk  input  1  peripheral clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  counter enable (level).
- count_reset  input  1  synchronous restart request (one-cycle pulse from the register file).
- upnotdown  input  1  1 = count up, 0 = count down.
- period  input  CNT_W  wrap value (live register).
- prescale  input  PRE_W  a tick occurs every prescale+1 clk cycles (live register).
- count_val  output  CNT_W  current count, registered; feeds the PWM stage.
- overflow  output  1  one-cycle pulse on an up-count wrap.
- underflow  output  1  one-cycle pulse on a down-count wrap.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low. All state is updated on the clk rising edge only.
- Reset values: count_val=0, overflow=0, underflow=0, prescaler counter=0, period_sh=0, prescale_sh=0.
- Internal state:
  - pre_cnt (PRE_W bits).
  - period_sh and prescale_sh (shadow copies of period and prescale).
- Priority per cycle: rst_n, then count_reset, then en, then normal counting.
- count_reset=1:
  - count_val<=0, pre_cnt<=0.
  - period_sh<=period, prescale_sh<=prescale.
  - No overflow/underflow pulse. Acts regardless of en.
- en=0:
  - count_val holds, pre_cnt<=0, pulses 0.
  - Shadows track live period/prescale every cycle.
- en=1, prescaler:
  - If pre_cnt==prescale_sh: tick=1 and pre_cnt<=0.
  - Else: pre_cnt<=pre_cnt+1, no tick.
  - With prescale_sh=0 there is a tick every cycle.
- Up count on tick:
  - If count_val>=period_sh: count_val<=0, overflow<=1 for exactly one cycle, shadows reload from live inputs.
  - Else: count_val<=count_val+1.
- Down count on tick:
  - If count_val==0: count_val<=period_sh, underflow<=1 for one cycle, shadows reload. The reload uses the old period_sh; the new shadow applies from the next wrap.
  - Else: count_val<=count_val-1.
- Sequence length: the up sequence is 0..P (P+1 states). The down sequence is P..0.
- Latency: count_val changes in the cycle after the tick edge. The pulse is asserted in the same cycle that count_val shows the wrapped value.
- Boundaries:
  - period_sh=0: count_val stays 0. overflow (up) or underflow (down) pulses on every tick.
  - count_val>period_sh is possible only after enabling with a smaller period. In up mode the next tick wraps to 0 with overflow. In down mode it decrements normally.
  - Counter arithmetic is modulo 2^CNT_W internally but never wraps, because of the compares above.
- Direction change mid-count: takes effect on the next tick from the current value, with no reload and no pulse.
- Changes to period/prescale while running: invisible until the next wrap or count_reset.
- Toggling en: resumes from the held count_val with a fresh prescale cycle.
- rst_n asserted mid-count: all outputs go to reset values immediately (asynchronously).

Test Plan:
1. Reset, then en=1, up, period=4, prescale=0: count_val 0,1,2,3,4,0,… with overflow high exactly in the cycles where count_val returns to 0, every 5 cycles.
2. en=1, up, period=3, prescale=2: each count value is held 3 cycles, giving an overflow period of 12 clk.
3. Down mode, period=3, prescale=0, after count_reset: count_val 0,3,2,1,0,3, with underflow pulsing on each 0→3 transition.
4. Running up, period=9, count_val=5; write period=2: count continues 6..9, then 0. The next cycle wraps at 2 (0,1,2,0).
5. Running up with count_val=7: pulse count_reset together with en=0. count_val=0 next cycle and no overflow. Then assert rst_n low mid-count: count_val=0 asynchronously.
6. period=0, up, prescale=1: count_val stays 0 and overflow pulses every 2 cycles. Switching upnotdown to 0 gives underflow pulses instead.
